// File: rtl/mmc1_serial_loader_if.sv
// CPU-side bus seen by the MMC1 serial loader: ROM select, R/W, A14:A13 and data.
// The CPU model drives it through master; the loader samples it through slave.
interface mmc1_serial_loader_if;
    logic       cpu_ce;
    logic       cpu_rw;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_dat;

    modport master (
        output cpu_ce,
        output cpu_rw,
        output cpu_addr,
        output cpu_dat
    );

    modport slave (
        input cpu_ce,
        input cpu_rw,
        input cpu_addr,
        input cpu_dat
    );
endinterface

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial register loader: filters CPU writes to $8000-$FFFF, assembles the
// 5-write LSB-first shift and presents four 5-bit control registers plus load strobes.
module mmc1_serial_loader #(
    parameter logic [4:0] R0_RST     = 5'b01100,
    parameter logic [4:0] R1_RST     = 5'b00000,
    parameter logic [4:0] R2_RST     = 5'b00000,
    parameter logic [4:0] R3_RST     = 5'b10000,
    parameter bit         RMW_FILTER = 1'b1
) (
    input  logic                       m2,
    input  logic                       map_rst,
    mmc1_serial_loader_if.slave        cpu,
    output logic [4:0]                 r0,
    output logic [4:0]                 r1,
    output logic [4:0]                 r2,
    output logic [4:0]                 r3,
    output logic                       wr_stb,
    output logic [1:0]                 wr_sel,
    output logic                       rst_stb,
    output logic [2:0]                 ctr,
    output logic [3:0]                 buff
);

    // Counts of 5..7 cannot occur, but are handled as a full shift if ever present.
    function automatic logic ctr_full(input logic [2:0] c);
        return (c >= 3'd4);
    endfunction

    function automatic logic [3:0] shift_in(input logic [3:0] b, input logic bit_in);
        return {bit_in, b[3:1]};
    endfunction

    logic       acc_p0;
    logic       accept_p0;
    logic       prev_acc;
    logic       unused_dat;

    logic [4:0] reg_q [4];
    logic [4:0] reg_d [4];
    logic [2:0] ctr_q,     ctr_d;
    logic [3:0] buff_q,    buff_d;
    logic       wr_stb_q,  wr_stb_d;
    logic [1:0] wr_sel_q,  wr_sel_d;
    logic       rst_stb_q, rst_stb_d;

    assign unused_dat = ^cpu.cpu_dat[6:1];

    // Stage p0: decode the bus cycle; the second of back-to-back writes is dropped when filtering.
    assign acc_p0    = !cpu.cpu_ce && !cpu.cpu_rw;
    assign accept_p0 = acc_p0 && (!RMW_FILTER || !prev_acc);

    always_comb begin
        reg_d     = reg_q;
        ctr_d     = ctr_q;
        buff_d    = buff_q;
        wr_stb_d  = 1'b0;
        wr_sel_d  = wr_sel_q;
        rst_stb_d = 1'b0;

        if (accept_p0) begin
            if (cpu.cpu_dat[7]) begin
                ctr_d           = 3'd0;
                buff_d          = 4'd0;
                reg_d[0][3:2]   = 2'b11;
                rst_stb_d       = 1'b1;
            end else if (!ctr_full(ctr_q)) begin
                buff_d = shift_in(buff_q, cpu.cpu_dat[0]);
                ctr_d  = ctr_q + 3'd1;
            end else begin
                reg_d[cpu.cpu_addr] = {cpu.cpu_dat[0], buff_q};
                ctr_d               = 3'd0;
                buff_d              = 4'd0;
                wr_stb_d            = 1'b1;
                wr_sel_d            = cpu.cpu_addr;
            end
        end
    end

    // Stage p1: all state commits on the falling edge of m2.
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            reg_q[0]  <= R0_RST;
            reg_q[1]  <= R1_RST;
            reg_q[2]  <= R2_RST;
            reg_q[3]  <= R3_RST;
            ctr_q     <= 3'd0;
            buff_q    <= 4'd0;
            prev_acc  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_sel_q  <= 2'd0;
            rst_stb_q <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            ctr_q     <= ctr_d;
            buff_q    <= buff_d;
            prev_acc  <= acc_p0;
            wr_stb_q  <= wr_stb_d;
            wr_sel_q  <= wr_sel_d;
            rst_stb_q <= rst_stb_d;
        end
    end

    assign r0      = reg_q[0];
    assign r1      = reg_q[1];
    assign r2      = reg_q[2];
    assign r3      = reg_q[3];
    assign ctr     = ctr_q;
    assign buff    = buff_q;
    assign wr_stb  = wr_stb_q;
    assign wr_sel  = wr_sel_q;
    assign rst_stb = rst_stb_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Bench for mmc1_serial_loader: one bus drives a filtered and an unfiltered instance,
// both compared against a bit-list reference model of the serial protocol.
module tb_mmc1_serial_loader;

    logic m2;
    logic map_rst;

    mmc1_serial_loader_if bus ();

    logic [4:0] r_o [2][4];
    logic       wr_stb_o  [2];
    logic [1:0] wr_sel_o  [2];
    logic       rst_stb_o [2];
    logic [2:0] ctr_o     [2];
    logic [3:0] buff_o    [2];

    mmc1_serial_loader #(.RMW_FILTER(1'b1)) dut_f (
        .m2(m2), .map_rst(map_rst), .cpu(bus),
        .r0(r_o[0][0]), .r1(r_o[0][1]), .r2(r_o[0][2]), .r3(r_o[0][3]),
        .wr_stb(wr_stb_o[0]), .wr_sel(wr_sel_o[0]), .rst_stb(rst_stb_o[0]),
        .ctr(ctr_o[0]), .buff(buff_o[0])
    );

    mmc1_serial_loader #(.RMW_FILTER(1'b0)) dut_n (
        .m2(m2), .map_rst(map_rst), .cpu(bus),
        .r0(r_o[1][0]), .r1(r_o[1][1]), .r2(r_o[1][2]), .r3(r_o[1][3]),
        .wr_stb(wr_stb_o[1]), .wr_sel(wr_sel_o[1]), .rst_stb(rst_stb_o[1]),
        .ctr(ctr_o[1]), .buff(buff_o[1])
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 filters back-to-back writes, index 1 does not.
    int mr    [2][4];
    int mcnt  [2];
    bit mbits [2][4];
    bit mprev [2];
    bit mwr   [2];
    bit mrs   [2];
    int msel  [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mr[i][0] = 12; mr[i][1] = 0; mr[i][2] = 0; mr[i][3] = 16;
            mcnt[i] = 0; mprev[i] = 0; mwr[i] = 0; mrs[i] = 0; msel[i] = 0;
        end
    endfunction

    function automatic int model_buff(int i);
        int b = 0;
        for (int j = 0; j < mcnt[i]; j++)
            if (mbits[i][j]) b += 1 << (4 - mcnt[i] + j);
        return b;
    endfunction

    function automatic void model_edge(bit ce, bit rw, int addr, logic [7:0] dat);
        for (int i = 0; i < 2; i++) begin
            bit acc = !ce && !rw;
            bit take = acc && (i == 1 || !mprev[i]);
            mprev[i] = acc;
            mwr[i] = 0;
            mrs[i] = 0;
            if (take) begin
                if (dat[7]) begin
                    mcnt[i] = 0;
                    mr[i][0] = mr[i][0] | 12;
                    mrs[i] = 1;
                end else if (mcnt[i] < 4) begin
                    mbits[i][mcnt[i]] = dat[0];
                    mcnt[i]++;
                end else begin
                    int v = dat[0] ? 16 : 0;
                    for (int j = 0; j < 4; j++) if (mbits[i][j]) v += 1 << j;
                    mr[i][addr] = v;
                    mcnt[i] = 0;
                    mwr[i] = 1;
                    msel[i] = addr;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s d%0d r%0d", tag, i, k), 8'(r_o[i][k]), 8'(mr[i][k]));
            chk($sformatf("%s d%0d ctr", tag, i), 8'(ctr_o[i]), 8'(mcnt[i]));
            chk($sformatf("%s d%0d buff", tag, i), 8'(buff_o[i]), 8'(model_buff(i)));
            chk($sformatf("%s d%0d wr_stb", tag, i), 8'(wr_stb_o[i]), 8'(mwr[i]));
            chk($sformatf("%s d%0d rst_stb", tag, i), 8'(rst_stb_o[i]), 8'(mrs[i]));
            if (mwr[i])
                chk($sformatf("%s d%0d wr_sel", tag, i), 8'(wr_sel_o[i]), 8'(msel[i]));
        end
    endtask

    // Present one bus cycle, let the falling edge sample it, check on the rising edge.
    task automatic step(input bit ce, input bit rw, input logic [1:0] a, input logic [7:0] d,
                        input string tag);
        bus.cpu_ce   = ce;
        bus.cpu_rw   = rw;
        bus.cpu_addr = a;
        bus.cpu_dat  = d;
        @(negedge m2);
        model_edge(ce, rw, int'(a), d);
        @(posedge m2);
        #1;
        check_all(tag);
    endtask

    task automatic wr1(input logic [1:0] a, input logic [7:0] d, input string tag);
        step(1'b0, 1'b0, a, d, tag);
        step(1'b1, 1'b1, 2'd0, 8'h00, {tag, " idle"});
    endtask

    initial begin
        map_rst      = 1'b1;
        bus.cpu_ce   = 1'b1;
        bus.cpu_rw   = 1'b1;
        bus.cpu_addr = 2'd0;
        bus.cpu_dat  = 8'h00;
        model_reset();
        repeat (2) @(posedge m2);
        #1;
        check_all("reset");
        chk("reset r0 lit", 8'(r_o[0][0]), 8'h0C);
        chk("reset r3 lit", 8'(r_o[0][3]), 8'h10);
        map_rst = 1'b0;

        // Serial load of r3 with 10101.
        wr1(2'd3, 8'h01, "r3 w1");
        wr1(2'd3, 8'h00, "r3 w2");
        wr1(2'd3, 8'h01, "r3 w3");
        wr1(2'd3, 8'h00, "r3 w4");
        step(1'b0, 1'b0, 2'd3, 8'h01, "r3 w5");
        chk("r3 load lit", 8'(r_o[0][3]), 8'h15);
        chk("r3 wr_sel lit", 8'(wr_sel_o[0]), 8'd3);
        chk("r3 wr_stb lit", 8'(wr_stb_o[0]), 8'd1);
        step(1'b1, 1'b1, 2'd0, 8'h00, "r3 after");
        chk("r3 stb drop lit", 8'(wr_stb_o[0]), 8'd0);

        // r0 = 00001, then a partial shift aborted by the reset bit, then r1 = 10110.
        wr1(2'd0, 8'h01, "r0 w1");
        for (int k = 0; k < 4; k++) wr1(2'd0, 8'h00, "r0 wn");
        chk("r0 load lit", 8'(r_o[0][0]), 8'h01);
        wr1(2'd0, 8'h01, "part1");
        wr1(2'd0, 8'h01, "part2");
        step(1'b0, 1'b0, 2'd0, 8'h80, "sreset");
        chk("sreset r0 lit", 8'(r_o[0][0]), 8'h0D);
        chk("sreset ctr lit", 8'(ctr_o[0]), 8'd0);
        chk("sreset rst_stb lit", 8'(rst_stb_o[0]), 8'd1);
        step(1'b1, 1'b1, 2'd0, 8'h00, "sreset idle");
        wr1(2'd1, 8'h00, "r1 w1");
        wr1(2'd1, 8'h01, "r1 w2");
        wr1(2'd1, 8'h01, "r1 w3");
        wr1(2'd1, 8'h00, "r1 w4");
        wr1(2'd1, 8'h01, "r1 w5");
        chk("r1 load lit", 8'(r_o[0][1]), 8'h16);

        // Back-to-back writes: filtered instance sees one, unfiltered sees two.
        step(1'b0, 1'b0, 2'd0, 8'h01, "rmw a");
        step(1'b0, 1'b0, 2'd0, 8'h00, "rmw b");
        chk("rmw f ctr lit", 8'(ctr_o[0]), 8'd1);
        chk("rmw f buff lit", 8'(buff_o[0]), 8'h8);
        chk("rmw n ctr lit", 8'(ctr_o[1]), 8'd2);
        chk("rmw n buff lit", 8'(buff_o[1]), 8'h4);
        step(1'b1, 1'b1, 2'd0, 8'h00, "rmw idle");

        // Reads and non-ROM writes are ignored.
        step(1'b0, 1'b1, 2'd0, 8'h01, "read");
        step(1'b1, 1'b0, 2'd0, 8'h81, "ce hi");
        step(1'b0, 1'b1, 2'd0, 8'h01, "read2");
        chk("ignore ctr lit", 8'(ctr_o[1]), 8'd2);

        // Async reset between edges after three writes.
        map_rst = 1'b1;
        #1;
        model_reset();
        map_rst = 1'b0;
        @(posedge m2);
        #1;
        for (int k = 0; k < 3; k++) wr1(2'd2, 8'h01, "pre arst");
        chk("pre arst ctr lit", 8'(ctr_o[0]), 8'd3);
        bus.cpu_ce = 1'b0;
        bus.cpu_rw = 1'b0;
        bus.cpu_dat = 8'h01;
        map_rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst ctr lit", 8'(ctr_o[0]), 8'd0);
        map_rst = 1'b0;
        // Write already asserted across the reset release is still accepted.
        step(1'b0, 1'b0, 2'd2, 8'h01, "post arst");
        chk("post arst ctr lit", 8'(ctr_o[0]), 8'd1);
        step(1'b1, 1'b1, 2'd0, 8'h00, "post idle");

        // Reset held across an edge wins over a write.
        bus.cpu_ce = 1'b0;
        bus.cpu_rw = 1'b0;
        bus.cpu_dat = 8'h01;
        map_rst = 1'b1;
        @(negedge m2);
        model_reset();
        @(posedge m2);
        #1;
        map_rst = 1'b0;
        check_all("rst prio");
        step(1'b1, 1'b1, 2'd0, 8'h00, "prio idle");

        // Target chosen by the fifth write's address.
        for (int k = 0; k < 4; k++) wr1(2'd0, 8'h00, "tgt w");
        step(1'b0, 1'b0, 2'd2, 8'h01, "tgt w5");
        chk("tgt r2 lit", 8'(r_o[0][2]), 8'h10);
        chk("tgt r0 lit", 8'(r_o[0][0]), 8'h0C);
        chk("tgt sel lit", 8'(wr_sel_o[0]), 8'd2);
        step(1'b1, 1'b1, 2'd0, 8'h00, "tgt idle");

        // Randomized traffic with occasional async resets.
        for (int n = 0; n < 500; n++) begin
            bit ce, rw;
            logic [1:0] a;
            logic [7:0] d;
            ce = ($urandom_range(0, 7) == 0);
            rw = ($urandom_range(0, 4) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            d[7] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 79) == 0) begin
                map_rst = 1'b1;
                #1;
                model_reset();
                map_rst = 1'b0;
            end
            step(ce, rw, a, d, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmc1_serial_loader.md
# mmc1_serial_loader

CPU-side serial register loader for the MMC1-family mappers, including mapper 105 (NES-EVENT). It sits directly upstream of the mapper banking, mirroring and IRQ-timer logic. It decodes CPU writes to $8000-$FFFF and applies the consecutive-write (read-modify-write) filter. It assembles the 5-write serial shift and presents four 5-bit control registers, plus one-cycle load strobes, to the downstream mapper core.

## Interface
- R0_RST, 5'b01100: reset value of r0 (control register: mirroring, PRG mode).
- R1_RST, 5'b00000: reset value of r1.
- R2_RST, 5'b00000: reset value of r2.
- R3_RST, 5'b10000: reset value of r3.
- RMW_FILTER, 1: 1 accepts only the first of back-to-back write cycles; 0 accepts every write cycle.

- m2  in  1  clock; all state updates on the falling edge of m2.
- map_rst  in  1  reset, asynchronous, active-high.
- cpu_ce  in  1  ROM-area select, active-low: 0 means the CPU address is in $8000-$FFFF.
- cpu_rw  in  1  CPU read/write: 1 = read, 0 = write.
- cpu_addr  in  2  CPU A14:A13; selects the target register.
- cpu_dat  in  8  CPU data bus; only bit 7 and bit 0 are used.
- r0, r1, r2, r3  out  5 each  control registers.
- wr_stb  out  1  one-cycle pulse when a register is loaded.
- wr_sel  out  2  index of the register loaded; valid while wr_stb = 1.
- rst_stb  out  1  one-cycle pulse on a serial-reset write.
- ctr  out  3  serial write count, 0..4 (exported for save-state).
- buff  out  4  partial shift value (exported for save-state).

## Operation
- Write cycle: acc = !cpu_ce & !cpu_rw, sampled at the m2 falling edge.
- Filter register prev_acc <= acc on every edge.
  - RMW_FILTER = 1: a write is accepted only when acc & !prev_acc.
  - RMW_FILTER = 0: a write is accepted whenever acc = 1.
- Accepted write with cpu_dat[7] = 1 (serial reset):
  - ctr <= 0, buff <= 0.
  - r0[3:2] <= 2'b11; r0[4], r0[1:0] and r1..r3 unchanged.
  - rst_stb <= 1.
- Accepted write with cpu_dat[7] = 0 and ctr < 4:
  - buff <= {cpu_dat[0], buff[3:1]} (LSB-first shift).
  - ctr <= ctr + 1.
- Accepted write with cpu_dat[7] = 0 and ctr == 4:
  - r[cpu_addr] <= {cpu_dat[0], buff[3:0]}.
  - ctr <= 0, buff <= 0.
  - wr_stb <= 1, wr_sel <= cpu_addr.
- Register select: A14:A13 = 0 -> r0 ($8000), 1 -> r1 ($A000), 2 -> r2 ($C000), 3 -> r3 ($E000).
- The cpu_addr value of the 5th write alone selects the target; earlier write addresses are irrelevant.
- Any edge without an accepted write:
  - wr_stb <= 0, rst_stb <= 0.
  - All other state holds.
- Reads (cpu_rw = 1) and writes outside ROM (cpu_ce = 1) never change r*, ctr or buff. They do update prev_acc, clearing it to 0.
- ctr never exceeds 4. Values 5-7 are unreachable, and if present they are treated as 4.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: r*, ctr, buff, wr_stb and rst_stb change at the m2 falling edge that samples the accepted write. They are visible to the downstream core for the whole next m2 cycle.
- wr_stb and rst_stb are exactly one m2 cycle wide. Two accepted writes on successive cycles (RMW_FILTER = 0) may produce strobes on successive cycles.
- map_rst asserted (asynchronous, takes effect immediately, no edge required):
  - r0..r3 <= R0_RST..R3_RST.
  - ctr <= 0, buff <= 0, prev_acc <= 0.
  - wr_stb <= 0, rst_stb <= 0.
- A reset mid-sequence discards the partial shift.
- The first write after map_rst deasserts is accepted, even if acc was already 1.
- map_rst takes priority over any write in the same cycle.
- With RMW_FILTER = 1, an RMW instruction (dummy write then real write on consecutive cycles) counts once, using the first write's data.

## Test plan
- Serial load of r3: after reset, 5 isolated writes to $E000 with data 01,00,01,00,01 -> r3 = 5'b10101, wr_stb high once with wr_sel = 3 after the 5th write; ctr = 0, buff = 0; r0 = 01100, r1 = r2 = 0.
- Reset bit mid-sequence: first a serial load sets r0 = 5'b00001. Then 2 writes to $8000 (data 01,01), then a write of $80 -> ctr = 0, buff = 0, r0 = 5'b01101, rst_stb one cycle, wr_stb never high. Then 5 writes to $A000 (data 00,01,01,00,01) -> r1 = 5'b10110.
- RMW filter: RMW_FILTER = 1, two consecutive write cycles to $8000 with data 01 then 00 -> ctr = 1, buff = 4'b1000. Same stimulus with RMW_FILTER = 0 -> ctr = 2, buff = 4'b0100.
- Ignored cycles: reads of $8000 with cpu_dat = $01, and writes with cpu_ce = 1 and cpu_dat = $81 -> r*, ctr and buff unchanged; no strobes.
- Async reset mid-operation: after 3 writes (ctr = 3), pulse map_rst between m2 edges -> ctr = 0, buff = 0, r* = parameter defaults immediately. A following isolated write is accepted (ctr = 1).
- Target by last address: 4 writes to $8000 then a 5th to $C000 with data 01 -> r2 loaded with bit 4 = 1, r0 unchanged, wr_sel = 2.
